// File: rtl/uart_tx_sb_ctrl.sv
// Purpose: memory-mapped UART transmitter on the system bus; 8N1/8E1/8N2/8E2 framing, LSB first.
// Latency: a DATA write launches START on the sampling edge; read data is registered (1 cycle).
// Backpressure: none; DATA writes while a frame is in progress are dropped. Optional parity via UART_TX_PARITY_EN.
module uart_tx_sb_ctrl #(
  parameter int unsigned DEFAULT_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o
);

  localparam logic [15:0] DIV_RST   = 16'(DEFAULT_DIV);
  localparam logic [11:0] OFF_DATA  = 12'h000;
  localparam logic [11:0] OFF_BUSY  = 12'h004;
  localparam logic [11:0] OFF_DIV   = 12'h008;
  localparam logic [11:0] OFF_PAR   = 12'h00C;
  localparam logic [11:0] OFF_STOP2 = 12'h010;
  localparam logic [11:0] OFF_RST   = 12'h024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        par_bit_q;
  logic        stop_second_q;

  // configuration registers and the copy latched for the frame in flight
  logic [15:0] div_q;
  logic        stop2_q;
  logic        par_en;
  logic [15:0] div_l_q;
  logic        par_l_q;
  logic        stop2_l_q;

  // bus decode; only the page offset matters, the decoder already selected us
  logic [11:0] off;
  logic        wr;
  logic        rd;
  logic        busy;
  logic        soft_rst;
  logic        data_wr;
  logic        div_wr;
  logic        cfg_wr_ok;
  logic        bit_end;
  logic [15:0] reload;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign off         = addr_i[11:0];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign busy        = (state_q != S_IDLE);
  assign cfg_wr_ok   = wr & ~busy;
  assign soft_rst    = wr & (off == OFF_RST) & wdata_i[0];
  assign data_wr     = cfg_wr_ok & (off == OFF_DATA);
  assign div_wr      = cfg_wr_ok & (off == OFF_DIV) & (wdata_i[15:0] != 16'd0);
  assign bit_end     = (cnt_q == 16'd0);
  assign reload      = div_l_q - 16'd1;
  assign unused_bits = ^{addr_i[31:12], wdata_i[31:16]};

  // DIV and STOP2: writable only while idle; a zero divisor is rejected
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= DIV_RST;
      stop2_q <= 1'b0;
    end else if (soft_rst) begin
      div_q   <= DIV_RST;
      stop2_q <= 1'b0;
    end else begin
      if (div_wr) begin
        div_q <= wdata_i[15:0];
      end
      if (cfg_wr_ok && (off == OFF_STOP2)) begin
        stop2_q <= wdata_i[0];
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  // PARITY_EN: writable only while idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_en_q <= 1'b0;
    end else if (soft_rst) begin
      par_en_q <= 1'b0;
    end else if (cfg_wr_ok && (off == OFF_PAR)) begin
      par_en_q <= wdata_i[0];
    end
  end
  assign par_en = par_en_q;
`else
  // parity hardware absent: register reads 0 and frames never carry a parity bit
  assign par_en = 1'b0;
`endif

  // read mux; write-only and unmapped offsets read as zero
  always_comb begin
    rd_mux = 32'd0;
    case (off)
      OFF_BUSY:  rd_mux = {31'd0, busy};
      OFF_DIV:   rd_mux = {16'd0, div_q};
      OFF_PAR:   rd_mux = {31'd0, par_en};
      OFF_STOP2: rd_mux = {31'd0, stop2_q};
      default:   rd_mux = 32'd0;
    endcase
  end

  // read data only moves on a read access; it holds through writes and soft reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= 32'd0;
    end else if (rd) begin
      rdata_o <= rd_mux;
    end
  end

  // frame sequencer: every state holds its bit for div_l_q clocks, tx_o is registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      tx_o          <= 1'b1;
      cnt_q         <= 16'd0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'd0;
      par_bit_q     <= 1'b0;
      stop_second_q <= 1'b0;
      div_l_q       <= DIV_RST;
      par_l_q       <= 1'b0;
      stop2_l_q     <= 1'b0;
    end else if (soft_rst) begin
      state_q       <= S_IDLE;
      tx_o          <= 1'b1;
      cnt_q         <= 16'd0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'd0;
      par_bit_q     <= 1'b0;
      stop_second_q <= 1'b0;
      div_l_q       <= DIV_RST;
      par_l_q       <= 1'b0;
      stop2_l_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_o <= 1'b1;
          if (data_wr) begin
            // latch the configuration so the whole frame is self-consistent
            state_q       <= S_START;
            tx_o          <= 1'b0;
            cnt_q         <= div_q - 16'd1;
            div_l_q       <= div_q;
            par_l_q       <= par_en;
            stop2_l_q     <= stop2_q;
            shreg_q       <= wdata_i[7:0];
            par_bit_q     <= ^wdata_i[7:0];
            bit_idx_q     <= 3'd0;
            stop_second_q <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            tx_o    <= shreg_q[0];
            cnt_q   <= reload;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= reload;
            if (bit_idx_q == 3'd7) begin
              if (par_l_q) begin
                state_q <= S_PARITY;
                tx_o    <= par_bit_q;
              end else begin
                state_q <= S_STOP;
                tx_o    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shreg_q   <= {1'b0, shreg_q[7:1]};
              tx_o      <= shreg_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            tx_o    <= 1'b1;
            cnt_q   <= reload;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          tx_o <= 1'b1;
          if (bit_end) begin
            if (stop2_l_q && !stop_second_q) begin
              stop_second_q <= 1'b1;
              cnt_q         <= reload;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_o    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sb_ctrl.md
# uart_tx_sb_ctrl

Memory-mapped UART transmitter peripheral on the processor system bus. It occupies one 4 KiB page, selected by the decoder's tx request line (page 0x80005). It accepts register writes and reads from the core and serialises bytes onto `tx_o` as 8-bit LSB-first frames. Parity and stop-bit count are configurable.

## Interface
- `DEFAULT_DIV`, default 868: reset value of the bit-period divisor, in clocks per bit (100 MHz / 115200).
- `clk_i`  input  1  system clock.
- `rst_ni`  input  1  reset; one clock; asynchronous, active-low.
- `req_i`  input  1  access request; this is the decoder tx select.
- `we_i`  input  1  write enable; qualified by `req_i`.
- `addr_i`  input  32  byte address; only `addr_i[11:0]` is decoded.
- `wdata_i`  input  32  write data.
- `rdata_o`  output  32  registered read data.
- `tx_o`  output  1  serial line; idles high.

## Operation
Register map (offset in `addr_i[11:0]`):
- 0x00 DATA, W: `wdata_i[7:0]` is the byte to send.
- 0x04 BUSY, R: bit0 is 1 while a frame is in progress.
- 0x08 DIV, R/W: `[15:0]`, clocks per bit.
- 0x0C PARITY_EN, R/W: bit0.
- 0x10 STOP2, R/W: bit0; 0 gives one stop bit, 1 gives two.
- 0x24 RST, W: writing bit0=1 performs a soft reset.
- Any other offset reads 0. Writes to any other offset are ignored.

Write rules:
- A DATA write while idle is accepted and launches a frame. A DATA write while busy is dropped, with no queueing.
- Writes to DIV, PARITY_EN or STOP2 while busy are ignored. The current frame always uses the configuration latched at launch.
- A DIV write of 0 is ignored.

FSM: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- START, DATA, PARITY and STOP each hold their bit for DIV clocks. A 16-bit down-counter reloads with DIV−1 at every bit boundary.
- DATA: a 3-bit counter steps from 0 to 7. `tx_o` = `shreg[0]`, and the shift register shifts right at each bit boundary.
- PARITY: entered only if PARITY_EN was 1 at launch. The bit is even parity, i.e. the XOR of the 8 data bits.
- STOP: `tx_o`=1 for one or two bit periods, per the latched STOP2.
- Soft reset: aborts any frame and restores all registers to reset values. On the next edge `tx_o`=1, BUSY=0 and the FSM is in IDLE.

## Timing
- Reset values: `tx_o`=1, `rdata_o`=0, BUSY=0, DIV=`DEFAULT_DIV`, PARITY_EN=0, STOP2=0, FSM in IDLE.
- Frame launch: on the edge that samples an accepted DATA write, the FSM enters START and `tx_o`=0 from that edge. BUSY reads 1 in the same cycle the read is sampled.
- Frame length is (1 + 8 + P + S) × DIV cycles, where P = PARITY_EN and S = 1 + STOP2. BUSY drops on the edge ending the last stop period.
- Back-to-back: a DATA write sampled in the first IDLE cycle launches immediately, so there is no idle gap beyond one bit-boundary edge.
- Reads: `rdata_o` updates on the edge that samples `req_i`=1, `we_i`=0. It holds its value otherwise, including during writes.
- Asynchronous reset mid-frame: `tx_o` goes high immediately, independent of the clock.

## Configuration
- `UART_TX_PARITY_EN`: when defined, the PARITY_EN register and PARITY state are implemented.
- When undefined: PARITY_EN reads 0, writes to it are ignored, the PARITY state is never entered, and frames never contain a parity bit.

## Test plan
- DIV=4, send 0xA5, no parity, 1 stop → `tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. BUSY=1 for exactly 40 cycles.
- With `UART_TX_PARITY_EN`: PARITY_EN=1, STOP2=1, DIV=4, send 0xA5 → stop bits preceded by parity bit 0. Frame is 48 cycles.
- Mid-frame, write DATA=0x3C and DIV=8 → both dropped. The frame completes at DIV=4. Reading DIV returns 4.
- Read 0x04 during a frame and after it → 1, then 0. Read 0x40 (unmapped) → 0.
- Write RST=1 at cycle 10 of a frame → next edge `tx_o`=1, BUSY=0, DIV=`DEFAULT_DIV`.
- Assert `rst_ni`=0 mid-bit → `tx_o`=1 immediately. After release, the next DATA write launches a clean frame.
